// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage and its direct-mapped I-cache.
package if_fetch_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned LINES    = 64;
  localparam int unsigned PIPE_N   = 6;
  localparam int unsigned INST_W   = 32;
  localparam int unsigned INDEX_W  = $clog2(LINES);
  localparam int unsigned TAG_W    = ADDR_W - 2 - INDEX_W;
  localparam int unsigned STALL_IF = 1;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StFlush
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: PC input, byte-wide memory-controller port and the IF/ID output bundle.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic [ADDR_W-1:0] pc_i;
  logic              pc_ce_i;
  logic              jump_i;
  logic [PIPE_N-1:0] stall_i;
  logic              stall_req_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_rdata_i;
  logic              mem_rvalid_i;
  logic [ADDR_W-1:0] if_pc_o;
  logic [INST_W-1:0] if_inst_o;
  logic              if_valid_o;

  modport master (
    input  pc_i, pc_ce_i, jump_i, stall_i, mem_rdata_i, mem_rvalid_i,
    output stall_req_o, mem_req_o, mem_addr_o, if_pc_o, if_inst_o, if_valid_o
  );

  modport slave (
    output pc_i, pc_ce_i, jump_i, stall_i, mem_rdata_i, mem_rvalid_i,
    input  stall_req_o, mem_req_o, mem_addr_o, if_pc_o, if_inst_o, if_valid_o
  );

endinterface

// File: rtl/if_fetch_icache_dm.sv
// Direct-mapped I-cache: one word per line, combinational read, synchronous write,
// valid bits cleared asynchronously by reset.
module icache_dm
  import if_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] i_rd_index,
  output logic               o_rd_valid,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [INST_W-1:0]  o_rd_data,
  input  logic               i_wr_en,
  input  logic [INDEX_W-1:0] i_wr_index,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [INST_W-1:0]  i_wr_data
);

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [INST_W-1:0] r_data [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are never read as a hit while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: I-cache lookup on pc, byte-serial miss fill from the memory
// controller, registered {pc, inst, valid} toward the IF/ID latch.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  if_fetch_if.master bus
);

  fetch_state_e      r_state;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [23:0]       r_word;
  logic [ADDR_W-1:0] r_if_pc;
  logic [INST_W-1:0] r_if_inst;
  logic              r_if_valid;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic               w_line_valid;
  logic [TAG_W-1:0]   w_line_tag;
  logic [INST_W-1:0]  w_line_data;
  logic               w_hit;
  logic               w_hold;
  logic               w_fill;
  logic [INST_W-1:0]  w_fill_word;
  logic               w_unused;

  assign w_index     = bus.pc_i[INDEX_W+1:2];
  assign w_tag       = bus.pc_i[ADDR_W-1:INDEX_W+2];
  assign w_hit       = w_line_valid && (w_line_tag == w_tag);
  assign w_hold      = bus.stall_i[STALL_IF];
  assign w_fill      = (r_state == StFetch) && bus.mem_rvalid_i && (r_byte_cnt == 2'd3);
  // Fourth byte goes straight into the line; only the lower three are buffered.
  assign w_fill_word = {bus.mem_rdata_i, r_word};
  assign w_unused    = ^{bus.pc_i[1:0], bus.stall_i[PIPE_N-1:STALL_IF+1], bus.stall_i[STALL_IF-1:0]};

  icache_dm u_icache (
    .clk        (clk),
    .rst        (rst),
    .i_rd_index (w_index),
    .o_rd_valid (w_line_valid),
    .o_rd_tag   (w_line_tag),
    .o_rd_data  (w_line_data),
    .i_wr_en    (w_fill),
    .i_wr_index (r_fetch_pc[INDEX_W+1:2]),
    .i_wr_tag   (r_fetch_pc[ADDR_W-1:INDEX_W+2]),
    .i_wr_data  (w_fill_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_byte_cnt <= 2'd0;
      r_fetch_pc <= '0;
      r_word     <= '0;
      r_if_pc    <= '0;
      r_if_inst  <= ZERO_WORD;
      r_if_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.jump_i) begin
            r_if_valid <= 1'b0;
            r_state    <= StFlush;
          end else if (bus.pc_ce_i && w_hit) begin
            if (!w_hold) begin
              r_if_pc    <= bus.pc_i;
              r_if_inst  <= w_line_data;
              r_if_valid <= 1'b1;
            end
          end else if (bus.pc_ce_i) begin
            r_fetch_pc <= bus.pc_i;
            r_byte_cnt <= 2'd0;
            r_state    <= StFetch;
            if (!w_hold) r_if_valid <= 1'b0;
          end else if (!w_hold) begin
            r_if_valid <= 1'b0;
          end
        end
        StFetch: begin
          if (bus.mem_rvalid_i) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0:    r_word[7:0]   <= bus.mem_rdata_i;
              2'd1:    r_word[15:8]  <= bus.mem_rdata_i;
              2'd2:    r_word[23:16] <= bus.mem_rdata_i;
              default: ;
            endcase
          end
          // A jump on the fourth byte still lets the line be written by w_fill.
          if (bus.jump_i) begin
            r_if_valid <= 1'b0;
            r_state    <= StFlush;
          end else if (w_fill) begin
            r_state <= StIdle;
          end
        end
        StFlush: begin
          if (bus.jump_i) r_if_valid <= 1'b0;
          else            r_state    <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.stall_req_o = ((r_state == StIdle) && bus.pc_ce_i && !w_hit && !bus.jump_i) ||
                           (r_state == StFetch) || (r_state == StFlush);
  assign bus.mem_req_o   = (r_state == StFetch);
  assign bus.mem_addr_o  = (r_state == StFetch) ? (r_fetch_pc + ADDR_W'(r_byte_cnt)) : '0;
  assign bus.if_pc_o     = r_if_pc;
  assign bus.if_inst_o   = r_if_inst;
  assign bus.if_valid_o  = r_if_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized fetches against a
// word-level cache/memory model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_if bus ();

  if_fetch u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]       mem [4096];
  bit               model_valid [LINES];
  logic [TAG_W-1:0] model_tag   [LINES];
  logic [31:0]      exp_pc, exp_inst;
  logic             exp_valid;
  bit               rsp_en = 1'b0;
  logic [31:0]      rsp_addrs [$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [11:0] b;
    b = a[11:0];
    return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return model_valid[a[7:2]] && (model_tag[a[7:2]] == a[31:8]);
  endfunction

  task automatic model_fill(input logic [31:0] a);
    model_valid[a[7:2]] = 1'b1;
    model_tag[a[7:2]]   = a[31:8];
  endtask

  // Memory controller: answers one byte per request, never on consecutive edges, random gaps.
  initial begin : responder
    logic req, busy;
    logic [31:0] addr;
    forever begin
      @(negedge clk);
      req  = bus.mem_req_o;
      addr = bus.mem_addr_o;
      busy = bus.mem_rvalid_i;
      @(posedge clk);
      #1;
      if (rsp_en) begin
        if (req && !busy && ($urandom_range(2) != 0)) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = mem[addr[11:0]];
          rsp_addrs.push_back(addr);
        end else begin
          bus.mem_rvalid_i = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fill(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (bus.stall_req_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    bus.pc_i = '0; bus.pc_ce_i = 1'b0; bus.jump_i = 1'b0; bus.stall_i = '0;
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.if_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.if_valid_o); end
    n_cmp++; if (bus.if_pc_o !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", bus.if_pc_o); end
    n_cmp++; if (bus.if_inst_o !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h want 0", bus.if_inst_o); end
    n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req_o); end
    n_cmp++; if (bus.stall_req_o !== 1'b0) begin n_err++; $display("FAIL rst_stall_req: got %b want 0", bus.stall_req_o); end
    step(); step();
    rst = 1'b1;
    step();
    n_cmp++; if (bus.mem_addr_o !== 32'h0) begin n_err++; $display("FAIL idle_mem_addr: got %h want 0", bus.mem_addr_o); end
    exp_pc = '0; exp_inst = '0; exp_valid = 1'b0;
  endtask

  task automatic test_cold_miss();
    bit ok;
    rsp_addrs.delete();
    rsp_en = 1'b1;
    bus.pc_i = 32'h0; bus.pc_ce_i = 1'b1;
    #1;
    n_cmp++; if (bus.stall_req_o !== 1'b1) begin n_err++; $display("FAIL cold_stall_req: got %b want 1", bus.stall_req_o); end
    wait_fill(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL cold_fill_timeout: got stall_req=%b want 0", bus.stall_req_o); end
    n_cmp++; if (rsp_addrs.size() != 4) begin n_err++; $display("FAIL cold_nbytes: got %0d want 4", rsp_addrs.size()); end
    for (int i = 0; i < rsp_addrs.size() && i < 4; i++) begin
      n_cmp++; if (rsp_addrs[i] !== 32'(i)) begin n_err++; $display("FAIL cold_addr%0d: got %h want %h", i, rsp_addrs[i], i); end
    end
    step();
    n_cmp++; if (bus.if_inst_o !== 32'h0050_0013) begin n_err++; $display("FAIL cold_inst: got %h want 00500013", bus.if_inst_o); end
    n_cmp++; if (bus.if_valid_o !== 1'b1) begin n_err++; $display("FAIL cold_valid: got %b want 1", bus.if_valid_o); end
    n_cmp++; if (bus.if_pc_o !== 32'h0) begin n_err++; $display("FAIL cold_pc: got %h want 0", bus.if_pc_o); end
    model_fill(32'h0);
    exp_pc = 32'h0; exp_inst = 32'h0050_0013; exp_valid = 1'b1;
  endtask

  task automatic test_hit();
    n_cmp++; if (bus.stall_req_o !== 1'b0) begin n_err++; $display("FAIL hit_stall_req: got %b want 0", bus.stall_req_o); end
    n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL hit_mem_req: got %b want 0", bus.mem_req_o); end
    bus.pc_ce_i = 1'b0;
    step();
    n_cmp++; if (bus.if_valid_o !== 1'b0) begin n_err++; $display("FAIL nofetch_valid: got %b want 0", bus.if_valid_o); end
    bus.pc_ce_i = 1'b1;
    step();
    n_cmp++; if (bus.if_valid_o !== 1'b1) begin n_err++; $display("FAIL hit_valid: got %b want 1", bus.if_valid_o); end
    n_cmp++; if (bus.if_inst_o !== word_at(32'h0)) begin n_err++; $display("FAIL hit_inst: got %h want %h", bus.if_inst_o, word_at(32'h0)); end
    n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL hit_no_mem: got %b want 0", bus.mem_req_o); end
  endtask

  task automatic test_stall_hold();
    bus.pc_ce_i = 1'b0;
    step();
    bus.stall_i[STALL_IF] = 1'b1; bus.pc_ce_i = 1'b1; bus.pc_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.if_valid_o !== 1'b0) begin n_err++; $display("FAIL stall_hold_valid%0d: got %b want 0", i, bus.if_valid_o); end
    end
    bus.stall_i = '0;
    step();
    n_cmp++; if (bus.if_valid_o !== 1'b1) begin n_err++; $display("FAIL stall_release_valid: got %b want 1", bus.if_valid_o); end
    bus.stall_i[STALL_IF] = 1'b1; bus.pc_ce_i = 1'b0;
    step();
    n_cmp++; if (bus.if_valid_o !== 1'b1) begin n_err++; $display("FAIL stall_hold_nofetch: got %b want 1", bus.if_valid_o); end
    bus.stall_i = '0; bus.pc_ce_i = 1'b1;
    step();
    exp_pc = 32'h0; exp_inst = word_at(32'h0); exp_valid = 1'b1;
  endtask

  task automatic test_alias();
    bit ok;
    logic [31:0] pcs [2];
    pcs[0] = 32'h100;
    pcs[1] = 32'h0;
    foreach (pcs[j]) begin
      bus.pc_i = pcs[j];
      #1;
      n_cmp++; if (bus.stall_req_o !== 1'b1) begin n_err++; $display("FAIL alias_miss%0d: got %b want 1", j, bus.stall_req_o); end
      wait_fill(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL alias_timeout%0d: got stall_req=%b want 0", j, bus.stall_req_o); end
      step();
      n_cmp++; if (bus.if_inst_o !== word_at(pcs[j])) begin n_err++; $display("FAIL alias_inst%0d: got %h want %h", j, bus.if_inst_o, word_at(pcs[j])); end
      n_cmp++; if (bus.if_pc_o !== pcs[j]) begin n_err++; $display("FAIL alias_pc%0d: got %h want %h", j, bus.if_pc_o, pcs[j]); end
      model_fill(pcs[j]);
    end
    exp_pc = 32'h0; exp_inst = word_at(32'h0); exp_valid = 1'b1;
  endtask

  task automatic test_jump_flush();
    bit ok;
    rsp_en = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.pc_i = 32'h84;
    step();
    n_cmp++; if (bus.mem_addr_o !== 32'h84) begin n_err++; $display("FAIL jmp_addr0: got %h want 84", bus.mem_addr_o); end
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = mem[12'h84];
    step();
    bus.mem_rvalid_i = 1'b0;
    n_cmp++; if (bus.mem_addr_o !== 32'h85) begin n_err++; $display("FAIL jmp_addr1: got %h want 85", bus.mem_addr_o); end
    step();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = mem[12'h85];
    step();
    bus.mem_rvalid_i = 1'b0; bus.jump_i = 1'b1;
    step();
    n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL jmp_mem_req: got %b want 0", bus.mem_req_o); end
    n_cmp++; if (bus.stall_req_o !== 1'b1) begin n_err++; $display("FAIL jmp_flush_stall: got %b want 1", bus.stall_req_o); end
    n_cmp++; if (bus.if_valid_o !== 1'b0) begin n_err++; $display("FAIL jmp_valid: got %b want 0", bus.if_valid_o); end
    bus.jump_i = 1'b0; bus.pc_ce_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 8'hAA;
    step();
    bus.mem_rvalid_i = 1'b0;
    n_cmp++; if (bus.stall_req_o !== 1'b0) begin n_err++; $display("FAIL jmp_one_flush: got %b want 0", bus.stall_req_o); end
    n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL jmp_stray_ignored: got %b want 0", bus.mem_req_o); end
    bus.pc_ce_i = 1'b1;
    #1;
    n_cmp++; if (bus.stall_req_o !== 1'b1) begin n_err++; $display("FAIL jmp_line_invalid: got %b want 1", bus.stall_req_o); end
    rsp_en = 1'b1;
    wait_fill(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL jmp_refill_timeout: got stall_req=%b want 0", bus.stall_req_o); end
    step();
    n_cmp++; if (bus.if_inst_o !== word_at(32'h84)) begin n_err++; $display("FAIL jmp_refill_inst: got %h want %h", bus.if_inst_o, word_at(32'h84)); end
    model_fill(32'h84);
    exp_pc = 32'h84; exp_inst = word_at(32'h84); exp_valid = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] pc, want;
    bit hit, stl, ok;
    for (int k = 0; k < 40; k++) begin
      pc   = 32'($urandom_range(32'hEFC)) & 32'hFFFF_FFFC;
      hit  = model_hit(pc);
      stl  = ($urandom_range(3) == 0);
      want = word_at(pc);
      bus.pc_i = pc; bus.pc_ce_i = 1'b1; bus.stall_i = '0;
      #1;
      n_cmp++; if (bus.stall_req_o !== !hit) begin n_err++; $display("FAIL rnd_stall_req k=%0d pc=%h: got %b want %b", k, pc, bus.stall_req_o, !hit); end
      wait_fill(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd_timeout k=%0d: got stall_req=%b want 0", k, bus.stall_req_o); end
      if (!hit) exp_valid = 1'b0;
      model_fill(pc);
      if (stl) begin
        bus.stall_i[STALL_IF] = 1'b1;
        step();
        n_cmp++;
        if ({bus.if_pc_o, bus.if_inst_o, bus.if_valid_o} !== {exp_pc, exp_inst, exp_valid}) begin
          n_err++;
          $display("FAIL rnd_hold k=%0d: got %h/%h/%b want %h/%h/%b", k, bus.if_pc_o, bus.if_inst_o,
                   bus.if_valid_o, exp_pc, exp_inst, exp_valid);
        end
        bus.stall_i = '0;
      end
      step();
      n_cmp++;
      if ({bus.if_pc_o, bus.if_inst_o, bus.if_valid_o} !== {pc, want, 1'b1}) begin
        n_err++;
        $display("FAIL rnd_out k=%0d: got %h/%h/%b want %h/%h/1", k, bus.if_pc_o, bus.if_inst_o,
                 bus.if_valid_o, pc, want);
      end
      exp_pc = pc; exp_inst = want; exp_valid = 1'b1;
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit ok;
    bus.pc_i = 32'hF00; bus.pc_ce_i = 1'b1;
    step(); step();
    n_cmp++; if (bus.mem_req_o !== 1'b1) begin n_err++; $display("FAIL rmf_in_fetch: got %b want 1", bus.mem_req_o); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL rmf_mem_req: got %b want 0", bus.mem_req_o); end
    n_cmp++;
    if ({bus.if_pc_o, bus.if_inst_o, bus.if_valid_o} !== 65'h0) begin
      n_err++;
      $display("FAIL rmf_outputs: got %h/%h/%b want 0/0/0", bus.if_pc_o, bus.if_inst_o, bus.if_valid_o);
    end
    step();
    rst = 1'b1;
    bus.pc_i = 32'h0;
    #1;
    n_cmp++; if (bus.stall_req_o !== 1'b1) begin n_err++; $display("FAIL rmf_valids_cleared: got %b want 1", bus.stall_req_o); end
    wait_fill(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rmf_timeout: got stall_req=%b want 0", bus.stall_req_o); end
    step();
    n_cmp++; if (bus.if_inst_o !== 32'h0050_0013) begin n_err++; $display("FAIL rmf_inst: got %h want 00500013", bus.if_inst_o); end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    foreach (mem[i]) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;
    foreach (model_valid[i]) begin
      model_valid[i] = 1'b0;
      model_tag[i]   = '0;
    end
    test_reset();
    test_cold_miss();
    test_hit();
    test_stall_hold();
    test_alias();
    test_jump_flush();
    test_random();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
